// File: rtl/serial_link_credit_receiver.sv
// serial_link_credit_receiver: receive side of a credit-flow-controlled
// serial link. Data packets are buffered in a NumCredits-deep FIFO;
// credits carried by every packet are extracted and pulsed to the
// transmit side; pops are counted so they can be returned as credits.
// Optional feature macro: SERIAL_LINK_CREDIT_RX_BYPASS_EN (same-cycle
// bypass of a data packet into an empty buffer when the sink is ready).

module serial_link_credit_receiver_checker #(
  parameter type credit_t   = logic,
  parameter int  NumCredits = 2
) (
  input logic    clk_i,
  input logic    rst_i,
  input credit_t credits_to_return
);
  // Pending return credits can never exceed the receive buffer depth
  a_credits_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
    int'(credits_to_return) <= NumCredits);
endmodule

module serial_link_credit_receiver #(
  parameter type data_t     = logic,
  parameter type credit_t   = logic,
  parameter int  NumCredits = -1
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    pkt_valid_i,
  input  data_t   pkt_data_i,
  input  credit_t pkt_credits_i,
  input  logic    pkt_credits_only_i,
  output data_t   data_o,
  output logic    data_valid_o,
  input  logic    data_ready_i,
  output credit_t credits_received_o,
  output logic    credits_received_valid_o,
  output credit_t credits_to_return_o,
  input  logic    credits_returned_i,
  output logic    overflow_o
);
  localparam int Depth = (NumCredits >= 2) ? NumCredits : 2;
  localparam int PtrW  = $clog2(Depth);
  localparam int CntW  = $clog2(Depth + 1);

  if (NumCredits < 2) begin : g_bad_depth
    $error("serial_link_credit_receiver: NumCredits must be >= 2");
  end
  if ($bits(credit_t) < $clog2(Depth + 1)) begin : g_bad_credit_width
    $error("serial_link_credit_receiver: credit_t too narrow for NumCredits");
  end

  data_t           mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q, wptr_next_s, rptr_next_s;
  logic [CntW-1:0] count_q, count_next_s;
  data_t           head_q, head_next_s;
  logic            valid_q;
  credit_t         ret_q, ret_next_s;
  credit_t         crx_q;
  logic            crx_valid_q;
  logic            overflow_q;
  logic            push_s, full_s, bypass_s, fifo_pop_s, pop_s, store_s, drop_s;

  // Pointer advance with wrap at Depth (need not be a power of two)
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) begin
      return {PtrW{1'b0}};
    end else begin
      return p + PtrW'(1);
    end
  endfunction

  // Push/pop decisions, next pointers, occupancy, head and credit counter
  always_comb begin
    push_s = pkt_valid_i & ~pkt_credits_only_i;
    full_s = (count_q == CntW'(Depth));
`ifdef SERIAL_LINK_CREDIT_RX_BYPASS_EN
    bypass_s = push_s & data_ready_i & (count_q == {CntW{1'b0}}) & ~rst_i;
`else
    bypass_s = 1'b0;
`endif
    fifo_pop_s = valid_q & data_ready_i;
    pop_s      = fifo_pop_s | bypass_s;
    // A full buffer still accepts a push when the head leaves this cycle
    store_s    = push_s & ~bypass_s & (~full_s | fifo_pop_s);
    drop_s     = push_s & full_s & ~fifo_pop_s;

    wptr_next_s = store_s ? ptr_inc(wptr_q) : wptr_q;
    rptr_next_s = fifo_pop_s ? ptr_inc(rptr_q) : rptr_q;

    case ({store_s, fifo_pop_s})
      2'b10:   count_next_s = count_q + CntW'(1);
      2'b01:   count_next_s = count_q - CntW'(1);
      default: count_next_s = count_q;
    endcase

    // Head register tracks the element that will be at the front next cycle
    if (fifo_pop_s) begin
      if (count_q > CntW'(1)) begin
        head_next_s = mem_q[rptr_next_s];
      end else if (store_s) begin
        head_next_s = pkt_data_i;
      end else begin
        head_next_s = '0;
      end
    end else if ((count_q == {CntW{1'b0}}) && store_s) begin
      head_next_s = pkt_data_i;
    end else begin
      head_next_s = head_q;
    end

    // A pop coincident with a return must survive the reload
    if (credits_returned_i) begin
      ret_next_s = pop_s ? credit_t'(1) : credit_t'(0);
    end else if (pop_s && (ret_q != credit_t'(Depth))) begin
      ret_next_s = ret_q + credit_t'(1);
    end else begin
      ret_next_s = ret_q;
    end
  end

  // Buffer storage; contents are meaningless once pointers are reset
  always_ff @(posedge clk_i) begin
    if (store_s && !rst_i) begin
      mem_q[wptr_q] <= pkt_data_i;
    end
  end

  // Control state, registered outputs and sticky overflow
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q      <= {PtrW{1'b0}};
      rptr_q      <= {PtrW{1'b0}};
      count_q     <= {CntW{1'b0}};
      head_q      <= '0;
      valid_q     <= 1'b0;
      ret_q       <= credit_t'(0);
      crx_q       <= credit_t'(0);
      crx_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wptr_q      <= wptr_next_s;
      rptr_q      <= rptr_next_s;
      count_q     <= count_next_s;
      head_q      <= head_next_s;
      valid_q     <= (count_next_s != {CntW{1'b0}});
      ret_q       <= ret_next_s;
      crx_valid_q <= pkt_valid_i & (pkt_credits_i != credit_t'(0));
      crx_q       <= (pkt_valid_i && (pkt_credits_i != credit_t'(0))) ? pkt_credits_i : credit_t'(0);
      overflow_q  <= overflow_q | drop_s;
    end
  end

`ifdef SERIAL_LINK_CREDIT_RX_BYPASS_EN
  assign data_valid_o = valid_q | bypass_s;
  assign data_o       = bypass_s ? pkt_data_i : head_q;
`else
  assign data_valid_o = valid_q;
  assign data_o       = head_q;
`endif
  assign credits_received_o       = crx_q;
  assign credits_received_valid_o = crx_valid_q;
  assign credits_to_return_o      = ret_q;
  assign overflow_o               = overflow_q;

  serial_link_credit_receiver_checker #(
    .credit_t   (credit_t),
    .NumCredits (Depth)
  ) u_checker (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .credits_to_return (ret_q)
  );
endmodule

// File: tb/tb_serial_link_credit_receiver.sv
// Self-checking bench for serial_link_credit_receiver (NumCredits = 4,
// 8-bit payload, 3-bit credits). Directed scenarios followed by random
// traffic compared against a queue-based reference model.

module tb_serial_link_credit_receiver;
  localparam int N = 4;
  typedef logic [7:0] data_t;
  typedef logic [2:0] credit_t;

  logic    clk = 1'b0;
  logic    rst = 1'b0;
  logic    pkt_valid = 1'b0;
  data_t   pkt_data = '0;
  credit_t pkt_credits = '0;
  logic    pkt_co = 1'b0;
  data_t   data_o;
  logic    data_valid;
  logic    data_ready = 1'b0;
  credit_t crx;
  logic    crx_valid;
  credit_t ret;
  logic    returned = 1'b0;
  logic    ovf;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model state
  data_t   m_q[$];
  logic    m_ovf = 1'b0;
  int      m_ret = 0;
  logic    m_crx_v = 1'b0;
  int      m_crx = 0;

  serial_link_credit_receiver #(
    .data_t     (data_t),
    .credit_t   (credit_t),
    .NumCredits (N)
  ) dut (
    .clk_i                    (clk),
    .rst_i                    (rst),
    .pkt_valid_i              (pkt_valid),
    .pkt_data_i               (pkt_data),
    .pkt_credits_i            (pkt_credits),
    .pkt_credits_only_i       (pkt_co),
    .data_o                   (data_o),
    .data_valid_o             (data_valid),
    .data_ready_i             (data_ready),
    .credits_received_o       (crx),
    .credits_received_valid_o (crx_valid),
    .credits_to_return_o      (ret),
    .credits_returned_i       (returned),
    .overflow_o               (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("valid", data_valid, m_q.size() != 0);
    if (m_q.size() != 0) check("data", data_o, m_q[0]);
    check("crx_valid", crx_valid, m_crx_v);
    if (m_crx_v) check("crx", crx, m_crx);
    check("ret", ret, m_ret);
    check("ovf", ovf, m_ovf);
  endtask

  // One clock: drive inputs, advance the model at the edge, check after it
  task automatic cycle(input logic r, input logic v, input logic co, input data_t d,
                       input credit_t cr, input logic rdy, input logic rtn);
    logic pop;
    rst = r; pkt_valid = v; pkt_co = co; pkt_data = d; pkt_credits = cr;
    data_ready = rdy; returned = rtn;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_ovf = 1'b0; m_ret = 0; m_crx_v = 1'b0; m_crx = 0;
    end else begin
      pop = (m_q.size() != 0) && rdy;
      if (pop) void'(m_q.pop_front());
      if (v && !co) begin
        if (m_q.size() < N) m_q.push_back(d);
        else m_ovf = 1'b1;
      end
      m_crx_v = v && (cr != 0);
      m_crx   = cr;
      if (rtn) m_ret = pop ? 1 : 0;
      else if (pop) m_ret = (m_ret + 1 > N) ? N : m_ret + 1;
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b1, 1'b0, 8'h3C, 3'd5, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 8'h7E, 3'd1, 1'b1, 1'b0);
    check("rst_data", data_o, 8'h00);
    check("rst_crx", crx, 3'd0);
  endtask

  initial begin
    // Basic transfer: payload A5 with 3 credits, sink ready
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 8'hA5, 3'd3, 1'b1, 1'b0);
    check("r032_valid", data_valid, 1'b1);
    check("r032_data", data_o, 8'hA5);
    check("r032_crx", crx, 3'd3);
    check("r032_crx_v", crx_valid, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    check("r032_ret", ret, 3'd1);
    check("r032_pulse_end", crx_valid, 1'b0);

    // Overflow: five packets into a four-deep buffer with sink stalled
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 1'b1, 1'b0, data_t'(i), 3'd0, 1'b0, 1'b0);
      check("r033_ovf_timing", ovf, i == 5);
    end
    for (int i = 1; i <= 4; i++) begin
      check("r033_drain", data_o, data_t'(i));
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    end
    check("r033_empty", data_valid, 1'b0);
    check("r033_sticky", ovf, 1'b1);

    // Full buffer, simultaneous push and pop
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, data_t'(8'h10 + i), 3'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 8'h14, 3'd0, 1'b1, 1'b0);
    check("r034_ovf", ovf, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    check("r034_new_head", data_o, 8'h14);
    check("r034_valid", data_valid, 1'b1);

    // Credits-only packet is not stored
    do_reset();
    cycle(1'b0, 1'b1, 1'b1, 8'hFF, 3'd2, 1'b1, 1'b0);
    check("r035_crx", crx, 3'd2);
    check("r035_valid", data_valid, 1'b0);

    // Return coincident with a pop keeps that pop
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, data_t'(8'h20 + i), 3'd0, 1'b1, 1'b0);
    check("r036_ret3", ret, 3'd3);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
    check("r036_ret1", ret, 3'd1);

    // Random traffic with occasional returns and resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(199, 0) == 0,
            $urandom_range(3, 0) != 0,
            $urandom_range(4, 0) == 0,
            data_t'($urandom),
            credit_t'($urandom_range(4, 0) == 0 ? 0 : $urandom),
            $urandom_range(2, 0) == 0,
            $urandom_range(9, 0) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
